// File: rtl/latch_drv.sv
// latch_drv -- write-side driver/checker for a transparent, level-sensitive
// cross-coupled-NAND latch (pins clk, d, q, qb).
//
// A word accepted on start is written into the latch one bit at a time, LSB
// first. Each bit runs SETUP -> OPEN -> HOLD -> SAMPLE. lat_d moves only on
// entry to SETUP. lat_en is high only in OPEN. As a result lat_d is stable for
// SETUP_CYC cycles before the enable opens and for HOLD_CYC+1 cycles after it
// closes. In SAMPLE the q/qb pair is read back and checked against the bit
// just written.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   write request, honoured only in IDLE
//   data_in  in   [WIDTH] word to write, captured on the accepted start
//   lat_en   out  latch clk pin (enable)
//   lat_d    out  latch d pin
//   lat_q    in   latch q readback
//   lat_qb   in   latch qb readback
//   busy     out  high from SETUP of bit 0 through SAMPLE of the last bit
//   done     out  one-cycle pulse when the word is complete
//   rdata    out  [WIDTH] bits read back from lat_q
//   err      out  sticky per-word error (q==qb, or q differs from written bit)
//   err_cnt  out  [8] saturating count of failing SAMPLE cycles across all
//                 words, cleared only by rst (present only when
//                 LATCH_DRV_ERRCNT_EN is defined)
//
// Optional feature macro: LATCH_DRV_ERRCNT_EN
module latch_drv #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             lat_en,
  output logic             lat_d,
  input  logic             lat_q,
  input  logic             lat_qb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             err
`ifdef LATCH_DRV_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int MAX_CYC = (SETUP_CYC > OPEN_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((OPEN_CYC  > HOLD_CYC) ? OPEN_CYC  : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    phase_q, phase_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             lat_en_q, lat_en_d;
  logic             lat_d_q, lat_d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             bit_fail;
  logic [WIDTH-1:0] shift_nxt;
`ifdef LATCH_DRV_ERRCNT_EN
  logic [7:0]       err_cnt_q, err_cnt_d;
`endif

  // shift_q[0] is always the bit currently being written.
  assign shift_nxt = shift_q >> 1;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    lat_en_d  = lat_en_q;
    lat_d_d   = lat_d_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    bit_fail  = 1'b0;
`ifdef LATCH_DRV_ERRCNT_EN
    err_cnt_d = err_cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        lat_en_d = 1'b0;
        if (start) begin
          shift_d = data_in;
          lat_d_d = data_in[0];
          rdata_d = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          phase_d = '0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_q == CW'(SETUP_CYC - 1)) begin
          phase_d  = '0;
          lat_en_d = 1'b1;
          state_d  = S_OPEN;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_OPEN: begin
        if (phase_q == CW'(OPEN_CYC - 1)) begin
          phase_d  = '0;
          lat_en_d = 1'b0;
          state_d  = S_HOLD;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (phase_q == CW'(HOLD_CYC - 1)) begin
          phase_d = '0;
          state_d = S_SAMPLE;
        end else begin
          phase_d = phase_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        rdata_d[idx_q] = lat_q;
        // q==qb is an illegal latch state; q!=d is a wrong value.
        bit_fail = (lat_q == lat_qb) || (lat_q != shift_q[0]);
        if (bit_fail) begin
          err_d = 1'b1;
        end
`ifdef LATCH_DRV_ERRCNT_EN
        if (bit_fail && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
        if (idx_q == IW'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          shift_d = shift_nxt;
          lat_d_d = shift_nxt[0];
          state_d = S_SETUP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      lat_en_q  <= 1'b0;
      lat_d_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef LATCH_DRV_ERRCNT_EN
      err_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      lat_en_q  <= lat_en_d;
      lat_d_q   <= lat_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef LATCH_DRV_ERRCNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign lat_en = lat_en_q;
  assign lat_d  = lat_d_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
`ifdef LATCH_DRV_ERRCNT_EN
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_latch_drv.sv
// Self-checking bench for latch_drv with default parameters.
// A behavioural latch model (with injectable faults) sits on lat_q/lat_qb.
// Expected waveforms come from per-bit cycle arithmetic; expected readback
// comes from per-bit q/qb rules for each fault mode.
module tb_latch_drv;

  localparam int WIDTH    = 8;
  localparam int S        = 1;
  localparam int O        = 2;
  localparam int H        = 1;
  localparam int P        = S + O + H + 1;
  localparam int WORD_CYC = WIDTH * P + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             lat_en;
  logic             lat_d;
  logic             lat_q;
  logic             lat_qb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             err;
`ifdef LATCH_DRV_ERRCNT_EN
  logic [7:0]       err_cnt;
`endif

  latch_drv #(
    .WIDTH(WIDTH), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .lat_en(lat_en), .lat_d(lat_d), .lat_q(lat_q), .lat_qb(lat_qb),
    .busy(busy), .done(done), .rdata(rdata), .err(err)
`ifdef LATCH_DRV_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- latch model ----------------
  // mode 0: healthy latch; mode 1: q stuck at 0; mode 2: q=qb=1 during bit 3.
  logic lat_st = 1'b0;
  int   pulse_cnt = 0;
  int   base = 0;
  int   mode = 0;
  logic force_bit;

  always @(lat_en or lat_d) if (lat_en) lat_st = lat_d;
  always @(posedge lat_en) pulse_cnt = pulse_cnt + 1;

  assign force_bit = (mode == 2) && ((pulse_cnt - base) == 4);
  assign lat_q     = (mode == 1) ? 1'b0 : (force_bit ? 1'b1 : lat_st);
  assign lat_qb    = force_bit ? 1'b1 : ~lat_st;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Readback expected from the latch fault rules, bit by bit.
  task automatic model(input logic [WIDTH-1:0] d, input int m,
                       output logic [WIDTH-1:0] r, output logic e, output int nf);
    logic q, qb;
    r  = '0;
    e  = 1'b0;
    nf = 0;
    for (int i = 0; i < WIDTH; i++) begin
      q  = d[i];
      qb = ~d[i];
      if (m == 1) q = 1'b0;
      if (m == 2 && i == 3) begin
        q  = 1'b1;
        qb = 1'b1;
      end
      r[i] = q;
      if (q == qb || q != d[i]) begin
        e = 1'b1;
        nf++;
      end
    end
  endtask

  // ---------------- driver ----------------
  // extra: also pulse start at cycle 10 and in the DONE cycle.
  // rst_at: nonzero asserts rst during that cycle and abandons the word.
  task automatic run_word(input logic [WIDTH-1:0] d, input int m,
                          input bit extra, input int rst_at);
    logic [WIDTH-1:0] er;
    logic ee, exp_en, exp_d, pen, pd, fell_prev;
    int nf, k, ph, ndone;
    model(d, m, er, ee, nf);
    exp_q.push_back(er);
    @(negedge clk);
    mode = m;
    base = pulse_cnt;
    pen = lat_en;
    pd = lat_d;
    fell_prev = 1'b0;
    ndone = 0;
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    for (int c = 1; c <= WORD_CYC; c++) begin
      k  = (c - 1) / P;
      ph = (c - 1) % P;
      exp_en = (c <= WIDTH * P) && (ph >= S) && (ph < S + O);
      if (c <= WIDTH * P) exp_d = d[k];
      else exp_d = d[WIDTH-1];
      chk1("lat_en", lat_en, exp_en);
      chk1("lat_d", lat_d, exp_d);
      chk1("busy", busy, c <= WIDTH * P);
      chk1("done", done, c == WORD_CYC);
      chk1("same_edge_toggle", (lat_en !== pen) && (lat_d !== pd), 1'b0);
      if (lat_en !== pen) chk1("d_stable_at_en_edge", lat_d, pd);
      if (fell_prev) chk1("d_stable_after_fall", lat_d, pd);
      fell_prev = pen && !lat_en;
      if (done === 1'b1) ndone++;
      if (c == rst_at) begin
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_lat_en", lat_en, 1'b0);
        chk1("rst_lat_d", lat_d, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk8("rst_rdata", rdata, 8'h00);
        chk1("rst_err", err, 1'b0);
`ifdef LATCH_DRV_ERRCNT_EN
        chk8("rst_err_cnt", err_cnt, 8'h00);
`endif
        exp_cnt = 0;
        rst = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      start = extra && (c == 10 || c == WORD_CYC);
      pen = lat_en;
      pd = lat_d;
      if (c < WORD_CYC) @(negedge clk);
    end
    chk8("rdata", rdata, exp_q.pop_front());
    chk1("err", err, ee);
    chk8("pulses", 8'(pulse_cnt - base), 8'(WIDTH));
    exp_cnt = (exp_cnt + nf > 255) ? 255 : exp_cnt + nf;
`ifdef LATCH_DRV_ERRCNT_EN
    chk8("err_cnt", err_cnt, 8'(exp_cnt));
`endif
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_lat_en", lat_en, 1'b0);
      chk1("idle_lat_d_held", lat_d, d[WIDTH-1]);
      chk8("idle_rdata", rdata, er);
      chk1("idle_err", err, ee);
    end
    chk8("done_pulses", 8'(ndone), 8'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk1("reset_lat_en", lat_en, 1'b0);
    chk1("reset_lat_d", lat_d, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk8("reset_rdata", rdata, 8'h00);
    chk1("reset_err", err, 1'b0);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);

    run_word(8'hA5, 0, 1'b0, 0);
    for (int w = 0; w < 6; w++)
      run_word(WIDTH'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b0, 0);
    run_word(8'hFF, 1, 1'b0, 0);
    run_word(8'h08, 2, 1'b0, 0);
    run_word(8'h5A, 0, 1'b0, 0);
    run_word(WIDTH'($urandom_range(0, 255)), 0, 1'b1, 0);
    run_word(WIDTH'($urandom_range(0, 255)), 1, 1'b0, 12);
    run_word(8'h3C, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
